// File: rtl/exception_unit.sv
// Exception/interrupt sequencer for the LEGv8 core: holds ELR/ESR/ERR, redirects fetch, flushes.
// Optional build macro EXC_COUNT_EN adds saturating IRQ/fault entry counters readable via SysSel=11.
module exception_unit #(
    parameter logic [63:0] VECTOR_ADDR  = 64'h0000_0000_0000_00D8,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  EStatus,
    input  logic        ERet,
    input  logic [63:0] PC_D,
    input  logic [1:0]  SysSel,
    output logic        Redirect,
    output logic [63:0] RedirectPC,
    output logic        Flush,
    output logic        ExcMode,
    output logic        ExtIAck,
    output logic        DoubleFault,
    output logic [63:0] SysRData
);

    typedef enum logic [1:0] {StNormal, StFlushIn, StHandler, StFlushOut} state_e;

    localparam logic [2:0] FlushLast = 3'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [63:0] elr_q, elr_d, err_q, err_d, redirect_pc_q, redirect_pc_d;
    logic [3:0]  esr_q, esr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        redirect_q, redirect_d, flush_q, flush_d, exc_mode_q, exc_mode_d;
    logic        ext_iack_q, ext_iack_d, df_q, df_d;
    logic        is_irq;
`ifdef EXC_COUNT_EN
    logic [15:0] irq_cnt_q, irq_cnt_d, fault_cnt_q, fault_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StNormal;
            elr_q         <= '0;
            esr_q         <= '0;
            err_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            cnt_q         <= '0;
            exc_mode_q    <= 1'b0;
            ext_iack_q    <= 1'b0;
            df_q          <= 1'b0;
`ifdef EXC_COUNT_EN
            irq_cnt_q     <= '0;
            fault_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            elr_q         <= elr_d;
            esr_q         <= esr_d;
            err_q         <= err_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            cnt_q         <= cnt_d;
            exc_mode_q    <= exc_mode_d;
            ext_iack_q    <= ext_iack_d;
            df_q          <= df_d;
`ifdef EXC_COUNT_EN
            irq_cnt_q     <= irq_cnt_d;
            fault_cnt_q   <= fault_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        elr_d         = elr_q;
        esr_d         = esr_q;
        err_d         = err_q;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        flush_d       = flush_q;
        cnt_d         = cnt_q;
        exc_mode_d    = exc_mode_q;
        ext_iack_d    = 1'b0;
        df_d          = df_q;
        is_irq        = (EStatus == 4'd1);
`ifdef EXC_COUNT_EN
        irq_cnt_d     = irq_cnt_q;
        fault_cnt_d   = fault_cnt_q;
`endif
        case (state_q)
            StNormal: begin
                if (EStatus != 4'd0) begin
                    // Unknown codes are folded into invalid-opcode (2).
                    esr_d         = is_irq ? 4'd1 : 4'd2;
                    err_d         = PC_D;
                    elr_d         = is_irq ? PC_D : PC_D + 64'd4;
                    redirect_d    = 1'b1;
                    redirect_pc_d = VECTOR_ADDR;
                    ext_iack_d    = is_irq;
                    exc_mode_d    = 1'b1;
                    flush_d       = 1'b1;
                    cnt_d         = FlushLast;
                    state_d       = StFlushIn;
`ifdef EXC_COUNT_EN
                    if (is_irq && irq_cnt_q != 16'hFFFF) irq_cnt_d = irq_cnt_q + 16'd1;
                    if (!is_irq && fault_cnt_q != 16'hFFFF) fault_cnt_d = fault_cnt_q + 16'd1;
`endif
                end
            end
            StFlushIn, StFlushOut: begin
                if (cnt_q == 3'd0) begin
                    flush_d = 1'b0;
                    state_d = (state_q == StFlushIn) ? StHandler : StNormal;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StHandler: begin
                if (ERet) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = elr_q;
                    exc_mode_d    = 1'b0;
                    flush_d       = 1'b1;
                    cnt_d         = FlushLast;
                    state_d       = StFlushOut;
                end else if (EStatus != 4'd0) begin
                    df_d = 1'b1;
                end
            end
            default: state_d = StNormal;
        endcase
    end

    always_comb begin
        case (SysSel)
            2'b00:   SysRData = elr_q;
            2'b01:   SysRData = {60'b0, esr_q};
            2'b10:   SysRData = err_q;
`ifdef EXC_COUNT_EN
            default: SysRData = {32'b0, irq_cnt_q, fault_cnt_q};
`else
            default: SysRData = 64'b0;
`endif
        endcase
    end

    assign Redirect    = redirect_q;
    assign RedirectPC  = redirect_pc_q;
    assign Flush       = flush_q;
    assign ExcMode     = exc_mode_q;
    assign ExtIAck     = ext_iack_q;
    assign DoubleFault = df_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: expectations queued at stimulus time, popped at each check.
module tb_exception_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  EStatus;
    logic        ERet;
    logic [63:0] PC_D;
    logic [1:0]  SysSel;
    logic        Redirect, Flush, ExcMode, ExtIAck, DoubleFault;
    logic [63:0] RedirectPC, SysRData;

    exception_unit dut (
        .clk        (clk),
        .reset      (reset),
        .EStatus    (EStatus),
        .ERet       (ERet),
        .PC_D       (PC_D),
        .SysSel     (SysSel),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .Flush      (Flush),
        .ExcMode    (ExcMode),
        .ExtIAck    (ExtIAck),
        .DoubleFault(DoubleFault),
        .SysRData   (SysRData)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   irq_n = 0;
    int   fault_n = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_sys(input logic [1:0] sel);
        SysSel = sel;
        #1;
        check(SysRData);
    endtask

    function automatic logic [63:0] cnt_exp();
`ifdef EXC_COUNT_EN
        return {32'b0, 16'(irq_n), 16'(fault_n)};
`else
        return 64'b0;
`endif
    endfunction

    // From the redirect cycle of an entry: finish FLUSH_IN, ERET, finish FLUSH_OUT.
    task automatic run_out();
        step();
        step();
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset = 1'b0; EStatus = 4'd2; ERet = 1'b0; PC_D = 64'h0; SysSel = 2'b00;
        push("rst_redirect", 0); push("rst_rpc", 0); push("rst_flush", 0);
        push("rst_excmode", 0); push("rst_iack", 0); push("rst_df", 0); push("rst_elr", 0);
        step(); step();
        check(64'(Redirect)); check(RedirectPC); check(64'(Flush));
        check(64'(ExcMode)); check(64'(ExtIAck)); check(64'(DoubleFault)); read_sys(2'b00);

        reset = 1'b1; EStatus = 4'd0; ERet = 1'b1;
        push("idle_redirect", 0); push("idle_flush", 0); push("eret_in_normal_elr", 0);
        step();
        check(64'(Redirect)); check(64'(Flush)); read_sys(2'b00);
        ERet = 1'b0;

        // Invalid opcode entry
        PC_D = 64'h40; EStatus = 4'd2;
        push("inv_redirect", 1); push("inv_rpc", 64'hD8); push("inv_iack", 0);
        push("inv_flush1", 1); push("inv_excmode", 1);
        step();
        fault_n++;
        check(64'(Redirect)); check(RedirectPC); check(64'(ExtIAck));
        check(64'(Flush)); check(64'(ExcMode));
        EStatus = 4'd0;
        push("inv_elr", 64'h40 + 64'd4); push("inv_esr", 2); push("inv_err", 64'h40);
        read_sys(2'b00); read_sys(2'b01); read_sys(2'b10);
        push("inv_flush2", 1); push("inv_pulse_end", 0);
        step();
        check(64'(Flush)); check(64'(Redirect));
        push("handler_flush", 0); push("handler_excmode", 1);
        step();
        check(64'(Flush)); check(64'(ExcMode));
        ERet = 1'b1;
        push("eret_redirect", 1); push("eret_rpc", 64'h44); push("eret_excmode", 0);
        push("eret_flush", 1);
        step();
        check(64'(Redirect)); check(RedirectPC); check(64'(ExcMode)); check(64'(Flush));
        ERet = 1'b0;
        step();
        push("flush_out_end", 0);
        step();
        check(64'(Flush));

        // IRQ entry and nested fault
        PC_D = 64'h100; EStatus = 4'd1;
        push("irq_redirect", 1); push("irq_iack", 1); push("irq_rpc", 64'hD8);
        step();
        irq_n++;
        check(64'(Redirect)); check(64'(ExtIAck)); check(RedirectPC);
        EStatus = 4'd0;
        push("irq_elr", 64'h100); push("irq_esr", 1);
        read_sys(2'b00); read_sys(2'b01);
        push("irq_iack_pulse", 0);
        step();
        check(64'(ExtIAck));
        step();
        EStatus = 4'd2;
        push("nest_df", 1); push("nest_redirect", 0);
        step();
        check(64'(DoubleFault)); check(64'(Redirect));
        push("nest_elr", 64'h100); push("nest_esr", 1); push("nest_err", 64'h100);
        read_sys(2'b00); read_sys(2'b01); read_sys(2'b10);
        ERet = 1'b1; EStatus = 4'd1;
        push("nest_eret_redirect", 1); push("nest_eret_rpc", 64'h100);
        push("nest_eret_df", 1); push("nest_eret_iack", 0);
        step();
        check(64'(Redirect)); check(RedirectPC); check(64'(DoubleFault)); check(64'(ExtIAck));
        ERet = 1'b0;
        // IRQ stays asserted through FLUSH_OUT; must be taken right after
        push("pend_flush_out_redirect", 0); push("pend_flush_out_iack", 0);
        step(); step();
        check(64'(Redirect)); check(64'(ExtIAck));
        push("pend_taken_redirect", 1); push("pend_taken_iack", 1);
        step();
        irq_n++;
        check(64'(Redirect)); check(64'(ExtIAck));
        EStatus = 4'd0;
        run_out();

        PC_D = 64'h200; EStatus = 4'd1;
        push("irq3_iack", 1);
        step();
        irq_n++;
        check(64'(ExtIAck));
        EStatus = 4'd0;
        run_out();

        // Wrap of PC+4 and MRS reads
        PC_D = 64'hFFFF_FFFF_FFFF_FFFC; EStatus = 4'd2;
        step();
        fault_n++;
        EStatus = 4'd0;
        push("wrap_elr", 64'h0); push("wrap_esr", 2); push("wrap_err", 64'hFFFF_FFFF_FFFF_FFFC);
        push("counters", cnt_exp());
        read_sys(2'b00); read_sys(2'b01); read_sys(2'b10); read_sys(2'b11);

        // Reset mid-flush abandons the sequence
        reset = 1'b0;
        push("midrst_flush", 0); push("midrst_excmode", 0); push("midrst_df", 0);
        push("midrst_redirect", 0); push("midrst_err", 0); push("midrst_cnt", 0);
        step();
        check(64'(Flush)); check(64'(ExcMode)); check(64'(DoubleFault));
        check(64'(Redirect)); read_sys(2'b10); read_sys(2'b11);
        reset = 1'b1;
        step();

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
